ram_responder: RTL

//   Memory-side responder for the core's ram_rd_* / ram_wr_* ports: byte-addressed data RAM

---
 rtl/ram_responder_pkg.sv | 13 +
 rtl/ram_responder_bank.sv | 27 ++
 rtl/ram_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_responder_pkg.sv
// Shared definitions for the RAM responder: default address width and the
// encodings of the clear engine states.
package ram_responder_pkg;

  localparam int RAM_ADDR_W      = 16;
  localparam int RAM_PORT_ADDR_W = 20;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_responder_bank.sv
// One byte-wide RAM bank: synchronous write port and two independent
// asynchronous read ports, so an unaligned word can fetch two rows at once.
module ram_responder_bank #(
  parameter int ROW_W = 15
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [7:0]       wr_data,
  input  logic [ROW_W-1:0] rd_row_a,
  output logic [7:0]       rd_data_a,
  input  logic [ROW_W-1:0] rd_row_b,
  output logic [7:0]       rd_data_b
);

  logic [7:0] mem [0:(1<<ROW_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_row_a];
  assign rd_data_b = mem[rd_row_b];

endmodule

// File: rtl/ram_responder.sv
// Byte-addressed data RAM for the core's ram_rd_*/ram_wr_* ports: even/odd
// banks, little-endian word access, write-first bypass and a post-reset clear.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ram_rd_en,
  input  logic                       ram_rd_we,
  input  logic [RAM_PORT_ADDR_W-1:0] ram_rd_addr,
  output logic [15:0]                ram_rd_data,
  input  logic                       ram_wr_en,
  input  logic                       ram_wr_we,
  input  logic [RAM_PORT_ADDR_W-1:0] ram_wr_addr,
  input  logic [15:0]                ram_wr_data,
  output logic                       init_busy,
  output ram_state_e                 clear_state
);

  localparam int ROW_W = ADDR_W - 1;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  ram_state_e       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic [ADDR_W-1:0] rd_lo, rd_hi, wr_lo, wr_hi;
  logic              wr_act, clearing;
  logic              ev_wr_lo, ev_wr_hi, od_wr_lo, od_wr_hi;
  logic              ev_we, od_we;
  logic [ROW_W-1:0]  ev_wr_row, od_wr_row;
  logic [7:0]        ev_wr_data, od_wr_data;
  logic [7:0]        ev_rd_a, ev_rd_b, od_rd_a, od_rd_b;
  logic [7:0]        arr_lo, arr_hi, lo_byte, hi_byte;
  logic              unused_addr;

  assign unused_addr = ^{ram_rd_addr[RAM_PORT_ADDR_W-1:ADDR_W],
                         ram_wr_addr[RAM_PORT_ADDR_W-1:ADDR_W]};

  // Word high byte is addr+1 truncated to ADDR_W bits, which gives the top-of-memory wrap.
  assign rd_lo = ram_rd_addr[ADDR_W-1:0];
  assign rd_hi = rd_lo + ADDR_W'(1);
  assign wr_lo = ram_wr_addr[ADDR_W-1:0];
  assign wr_hi = wr_lo + ADDR_W'(1);

  // Clear engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? RAM_CLEAR : RAM_READY;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      RAM_CLEAR: begin
        row_d = row_q + ROW_W'(1);
        if (row_q == LAST_ROW) begin
          state_d = RAM_READY;
        end
      end
      RAM_READY: state_d = RAM_READY;
      default:   state_d = RAM_READY;
    endcase
  end

  assign init_busy   = (state_q == RAM_CLEAR);
  assign clear_state = state_q;

  // rst gates the bank enables so nothing commits on an edge while reset is held.
  assign clearing = rst & init_busy;
  assign wr_act   = rst & ram_wr_en & ~init_busy;

  // A word write touches both banks; its two bytes always have opposite parity.
  assign ev_wr_lo = wr_act & ~wr_lo[0];
  assign ev_wr_hi = wr_act & ram_wr_we & ~wr_hi[0];
  assign od_wr_lo = wr_act & wr_lo[0];
  assign od_wr_hi = wr_act & ram_wr_we & wr_hi[0];

  assign ev_we      = clearing | ev_wr_lo | ev_wr_hi;
  assign ev_wr_row  = clearing ? row_q : (ev_wr_lo ? wr_lo[ADDR_W-1:1] : wr_hi[ADDR_W-1:1]);
  assign ev_wr_data = clearing ? 8'h00 : (ev_wr_lo ? ram_wr_data[7:0] : ram_wr_data[15:8]);

  assign od_we      = clearing | od_wr_lo | od_wr_hi;
  assign od_wr_row  = clearing ? row_q : (od_wr_lo ? wr_lo[ADDR_W-1:1] : wr_hi[ADDR_W-1:1]);
  assign od_wr_data = clearing ? 8'h00 : (od_wr_lo ? ram_wr_data[7:0] : ram_wr_data[15:8]);

  ram_responder_bank #(.ROW_W(ROW_W)) u_even (
    .clk       (clk),
    .we        (ev_we),
    .wr_row    (ev_wr_row),
    .wr_data   (ev_wr_data),
    .rd_row_a  (rd_lo[ADDR_W-1:1]),
    .rd_data_a (ev_rd_a),
    .rd_row_b  (rd_hi[ADDR_W-1:1]),
    .rd_data_b (ev_rd_b)
  );

  ram_responder_bank #(.ROW_W(ROW_W)) u_odd (
    .clk       (clk),
    .we        (od_we),
    .wr_row    (od_wr_row),
    .wr_data   (od_wr_data),
    .rd_row_a  (rd_lo[ADDR_W-1:1]),
    .rd_data_a (od_rd_a),
    .rd_row_b  (rd_hi[ADDR_W-1:1]),
    .rd_data_b (od_rd_b)
  );

  assign arr_lo = rd_lo[0] ? od_rd_a : ev_rd_a;
  assign arr_hi = rd_hi[0] ? od_rd_b : ev_rd_b;

  // Write-first bypass, resolved independently for each read byte.
  function automatic logic [7:0] fwd_byte(input logic [ADDR_W-1:0] a,
                                          input logic [7:0]        arr,
                                          input logic              act,
                                          input logic              word,
                                          input logic [ADDR_W-1:0] lo,
                                          input logic [ADDR_W-1:0] hi,
                                          input logic [15:0]       data);
    if (act && a == lo) begin
      return data[7:0];
    end else if (act && word && a == hi) begin
      return data[15:8];
    end
    return arr;
  endfunction

  assign lo_byte = fwd_byte(rd_lo, arr_lo, wr_act, ram_wr_we, wr_lo, wr_hi, ram_wr_data);
  assign hi_byte = fwd_byte(rd_hi, arr_hi, wr_act, ram_wr_we, wr_lo, wr_hi, ram_wr_data);

  assign ram_rd_data = (ram_rd_en && !init_busy) ? {(ram_rd_we ? hi_byte : 8'h00), lo_byte}
                                                 : 16'h0000;

endmodule
